// File: rtl/count_arbiter_if.sv
// count_arbiter_if: bundle of the request/grant signals between the
// requesters and the count_arbiter.
//   req     : one request bit per requester, held until its done/abort
//   len     : packed interval lengths, requester i in [i*WIDTH +: WIDTH]
//   grant   : one-hot owner of the counter, zero when idle
//   busy    : any grant active
//   value   : current counter value
//   done    : one-cycle pulse, owner's interval complete
//   abort   : one-cycle pulse, owner dropped req before completion
//   done_id : requester index belonging to the done/abort pulse
// Handshake: a requester raises req[i] and keeps it high until it sees done
// (or abort) with done_id == i; grant is the only indication of ownership.
interface count_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      value;
    logic                  done;
    logic                  abort;
    logic [IDW-1:0]        done_id;

    modport master (
        output req, len,
        input  grant, busy, value, done, abort, done_id
    );

    modport slave (
        input  req, len,
        output grant, busy, value, done, abort, done_id
    );
endinterface

// File: rtl/count_arbiter.sv
// count_arbiter: round-robin scheduler sharing one up-counter between NREQ
// requesters. The winner's length is captured, the counter runs 0..len_q,
// then done pulses and ownership moves on.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   bus       : count_arbiter_if slave (req/len in, grant/busy/value/
//               done/abort/done_id out)
//   fsm_state : current FSM state (0 IDLE, 1 COUNT, 2 FINISH)
module count_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    count_arbiter_if.slave  bus,
    output logic [1:0]      fsm_state
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COUNT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] len_q;
    logic             done;
    logic             abort;
    logic [IDW-1:0]   done_id;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   ptr;

    logic             pick_any;
    logic [IDW-1:0]   pick;
    logic [NREQ-1:0]  pick_hot;
    logic [WIDTH-1:0] pick_len;
    logic             owner_req;
    logic [IDW-1:0]   owner_next;

    // Round-robin search: offset k is the priority rank relative to ptr,
    // i is the requester it maps to. The first hit in rank order wins.
    always_comb begin
        pick_any = 1'b0;
        pick     = '0;
        pick_hot = '0;
        pick_len = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_any && bus.req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    pick_any    = 1'b1;
                    pick        = IDW'(i);
                    pick_hot    = '0;
                    pick_hot[i] = 1'b1;
                    pick_len    = bus.len[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // grant is one-hot on the owner while counting, so this is req[owner].
    assign owner_req  = |(bus.req & grant);
    assign owner_next = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            grant   <= '0;
            value   <= '0;
            len_q   <= '0;
            done    <= 1'b0;
            abort   <= 1'b0;
            done_id <= '0;
            owner   <= '0;
            ptr     <= '0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick;
                        len_q <= pick_len;
                        grant <= pick_hot;
                        value <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!owner_req) begin
                        abort   <= 1'b1;
                        done_id <= owner;
                        grant   <= '0;
                        ptr     <= owner_next;
                        state   <= IDLE;
                    end else if (value == len_q) begin
                        // done is registered here so it is high in FINISH.
                        done    <= 1'b1;
                        done_id <= owner;
                        state   <= FINISH;
                    end else begin
                        value <= value + WIDTH'(1);
                    end
                end
                FINISH: begin
                    grant <= '0;
                    ptr   <= owner_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant   = grant;
    assign bus.busy    = |grant;
    assign bus.value   = value;
    assign bus.done    = done;
    assign bus.abort   = abort;
    assign bus.done_id = done_id;
    assign fsm_state   = state;
endmodule

// File: tb/tb_count_arbiter.sv
module tb_count_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 3;

    logic       clk;
    logic       reset;
    logic [1:0] fsm_state;

    count_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    count_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    int n_checks;
    int n_fail;

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] lens;
        logic [NREQ-1:0]       exp_grant;
        int                    exp_id;
        int                    exp_len;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One full grant from an idle arbiter: request, ramp, done, release.
    task automatic run_vec(input vec_t v);
        bus.req = v.req;
        bus.len = v.lens;
        tick();
        check("vec_grant", 32'(bus.grant), 32'(v.exp_grant));
        check("vec_busy", 32'(bus.busy), 32'd1);
        check("vec_value0", 32'(bus.value), 32'd0);
        for (int m = 1; m <= v.exp_len; m++) begin
            tick();
            check("vec_value", 32'(bus.value), 32'(m));
        end
        tick();
        check("vec_done", 32'(bus.done), 32'd1);
        check("vec_done_id", 32'(bus.done_id), 32'(v.exp_id));
        check("vec_finish_grant", 32'(bus.grant), 32'(v.exp_grant));
        check("vec_state_finish", 32'(fsm_state), 32'd2);
        bus.req = '0;
        tick();
        check("vec_idle_grant", 32'(bus.grant), 32'd0);
        check("vec_idle_done", 32'(bus.done), 32'd0);
        check("vec_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int bad;
        n_checks = 0;
        n_fail   = 0;

        // Expected owners follow ptr: 0 -> 1 -> 3 -> 1 -> 0 -> 2 -> 2.
        vecs[0] = '{req: 4'b0001, lens: 32'h00000005, exp_grant: 4'b0001, exp_id: 0, exp_len: 5};
        vecs[1] = '{req: 4'b0101, lens: 32'h00000004, exp_grant: 4'b0100, exp_id: 2, exp_len: 0};
        vecs[2] = '{req: 4'b0011, lens: 32'h00000103, exp_grant: 4'b0001, exp_id: 0, exp_len: 3};
        vecs[3] = '{req: 4'b1001, lens: 32'h04000001, exp_grant: 4'b1000, exp_id: 3, exp_len: 4};
        vecs[4] = '{req: 4'b0110, lens: 32'h00070200, exp_grant: 4'b0010, exp_id: 1, exp_len: 2};
        vecs[5] = '{req: 4'b0010, lens: 32'h00000600, exp_grant: 4'b0010, exp_id: 1, exp_len: 6};

        reset   = 1'b0;
        bus.req = '0;
        bus.len = '0;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_value", 32'(bus.value), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_abort", 32'(bus.abort), 32'd0);
        check("rst_done_id", 32'(bus.done_id), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_no_req", 32'(bus.grant), 32'd0);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Round robin, all requesting, every len = 2, from ptr = 0.
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        bus.len = 32'h02020202;
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_grant", 32'(bus.grant), 32'(1 << (g % 4)));
            tick();
            tick();
            check("rr_hold", 32'(bus.grant), 32'(1 << (g % 4)));
            tick();
            check("rr_done", 32'(bus.done), 32'd1);
            check("rr_done_id", 32'(bus.done_id), 32'(g % 4));
            if (g == 4) bus.req = '0;
            tick();
            check("rr_gap", 32'(bus.grant), 32'd0);
        end

        // Maximum length on requester 1 (ptr = 1).
        bus.req = 4'b0010;
        bus.len = 32'h0000FF00;
        tick();
        check("max_grant", 32'(bus.grant), 32'b0010);
        bad = 0;
        for (int m = 1; m <= 255; m++) begin
            tick();
            if (bus.value !== 8'(m) || bus.done !== 1'b0) bad++;
        end
        check("max_ramp_errors", 32'(bad), 32'd0);
        tick();
        check("max_done", 32'(bus.done), 32'd1);
        check("max_value_hold", 32'(bus.value), 32'd255);
        check("max_done_id", 32'(bus.done_id), 32'd1);
        bus.req = '0;
        tick();
        check("max_idle", 32'(bus.grant), 32'd0);
        check("max_value_after", 32'(bus.value), 32'd255);

        // Abort on requester 3 at value 4 (ptr = 2).
        bus.req = 4'b1000;
        bus.len = 32'h0A000000;
        tick();
        check("ab_grant", 32'(bus.grant), 32'b1000);
        for (int m = 0; m < 4; m++) tick();
        check("ab_value4", 32'(bus.value), 32'd4);
        bus.req = '0;
        tick();
        check("ab_abort", 32'(bus.abort), 32'd1);
        check("ab_done_id", 32'(bus.done_id), 32'd3);
        check("ab_no_done", 32'(bus.done), 32'd0);
        check("ab_grant_off", 32'(bus.grant), 32'd0);
        check("ab_value_hold", 32'(bus.value), 32'd4);
        bus.req = 4'b0101;
        bus.len = 32'h00000005;
        tick();
        check("ab_pulse_once", 32'(bus.abort), 32'd0);
        check("ab_next_grant", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        tick();
        check("ab2_abort", 32'(bus.abort), 32'd1);
        check("ab2_done_id", 32'(bus.done_id), 32'd0);

        // Reset mid-count on requester 1 (ptr = 1).
        bus.req = 4'b0010;
        bus.len = 32'h00001400;
        tick();
        check("rm_grant", 32'(bus.grant), 32'b0010);
        for (int m = 0; m < 7; m++) tick();
        check("rm_value7", 32'(bus.value), 32'd7);
        reset = 1'b0;
        tick();
        check("rm_grant_off", 32'(bus.grant), 32'd0);
        check("rm_value_clr", 32'(bus.value), 32'd0);
        check("rm_busy", 32'(bus.busy), 32'd0);
        check("rm_no_pulse", 32'({bus.done, bus.abort}), 32'd0);
        reset = 1'b1;
        tick();
        check("rm_regrant", 32'(bus.grant), 32'b0010);
        bus.req = '0;
        tick();
        check("rm_abort", 32'(bus.abort), 32'd1);

        // len change during grant is ignored (ptr = 2, wraps to 0).
        bus.req = 4'b0001;
        bus.len = 32'h00000003;
        tick();
        check("lc_grant", 32'(bus.grant), 32'b0001);
        tick();
        check("lc_value1", 32'(bus.value), 32'd1);
        bus.len = 32'h00000009;
        tick();
        tick();
        check("lc_value3", 32'(bus.value), 32'd3);
        tick();
        check("lc_done", 32'(bus.done), 32'd1);
        check("lc_value_frozen", 32'(bus.value), 32'd3);
        bus.req = '0;
        tick();
        check("lc_idle", 32'(bus.grant), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/count_arbiter.md
# count_arbiter

Round-robin scheduler that shares one up-counter between `NREQ` requesters, each asking for a timed interval of `len` ticks. It sits in front of the counter datapath and owns its clear and enable sequencing. It grants the counter to exactly one requester at a time, runs it from 0 up to the captured length, then reports completion and passes ownership on.

## Interface

- `NREQ`, 4, number of requesters; 2..8.
- `WIDTH`, 8, counter and length width in bits.
- `IDW`, 3, width of `done_id`; must satisfy 2^IDW >= NREQ.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset: sampled on the rising edge of `clk`, state cleared when low.
- `req`  in  NREQ  request per requester; must be held until `done` for that requester.
- `len`  in  NREQ*WIDTH  packed lengths; requester i uses bits [i*WIDTH +: WIDTH].
- `grant`  out  NREQ  one-hot owner of the counter; all-zero when idle.
- `busy`  out  1  high while any grant is active.
- `value`  out  WIDTH  current counter value.
- `done`  out  1  one-cycle pulse: owner's interval complete.
- `abort`  out  1  one-cycle pulse: owner dropped `req` before completion.
- `done_id`  out  IDW  index of the requester for `done`/`abort`; valid only while either pulse is high.

## Operation

- FSM states: IDLE, COUNT, FINISH.
- IDLE:
  - If any `req` bit is high, pick the winner by round robin: the first set bit scanning upward from `ptr` and wrapping modulo NREQ.
  - Capture that requester's `len` into `len_q` and set `owner`.
  - Set `grant[owner]`, clear `value` to 0, go to COUNT.
  - If no `req` bit is high, stay in IDLE.
- COUNT: checks are evaluated in this priority order.
  - If `req[owner]` is 0: pulse `abort` with `done_id = owner`, clear `grant`, set `ptr = owner+1` (mod NREQ), go to IDLE.
  - Else if `value == len_q`: go to FINISH; `value` holds.
  - Else: `value` increments by 1.
- FINISH:
  - Pulse `done` with `done_id = owner`; `grant` stays high during this cycle.
  - Set `ptr = owner+1` (mod NREQ), go to IDLE.
- `len_q` is frozen for the whole grant; later changes on `len` are ignored.
- `value` compares by equality and never exceeds `len_q`, so no wrap is possible, including `len_q = 2^WIDTH-1`.
- `len = 0`: COUNT sees `value == 0` on its first cycle and goes straight to FINISH.
- If a requester keeps `req` high through FINISH, it re-competes in IDLE behind the others, since `ptr` has advanced past it.
- `busy` = OR of `grant`.
- `ptr` resets to 0.
- Reset values (`reset` low at an edge): `grant` = 0, `busy` = 0, `value` = 0, `done` = 0, `abort` = 0, `done_id` = 0, `ptr` = 0, state = IDLE.
- Reset mid-operation: the next edge with `reset` low forces the reset values. No `done` or `abort` is emitted, and the interrupted requester gets no completion.

## Timing

- Cycle numbering: cycle n is the cycle following rising edge n.
- `req[i]` first high at edge k in IDLE:
  - from edge k+1: `grant[i]` = 1, `value` = 0.
  - `value` = m after edge k+1+m, for m = 0..len.
  - after edge k+len+2: FINISH, `done` = 1 for one cycle.
  - after edge k+len+3: back in IDLE, `grant` = 0.
- Grant duration: `len`+2 cycles.
- Turnaround: at least one IDLE cycle with `grant` = 0 between consecutive grants.
- `abort`: appears the cycle after the edge at which `req[owner]` is sampled low in COUNT.
- `value` after `done` or `abort`: holds its last value until the next grant clears it.
- All outputs are registered; there is no combinational path from `req` to `grant`.

## Test plan

- **Single requester:** `req[0]` high, `len0` = 5, NREQ = 4 -> `grant` = 0001; `value` runs 0,1,2,3,4,5 on consecutive cycles; `done` = 1 one cycle later with `done_id` = 0; `grant` = 0 the cycle after.
- **Round robin:** `req` = 1111 held throughout, every `len` = 2 -> grants appear in order 0001, 0010, 0100, 1000, 0001; each grant lasts 4 cycles with a one-cycle IDLE gap between grants.
- **Zero and maximum length:** `len2` = 0 -> `grant` = 0100 for 2 cycles, `value` stays 0, `done_id` = 2. `len1` = 255 -> `value` reaches 255 and holds (no wrap to 0); `done` fires at grant cycle 257.
- **Abort:** `req[3]` high, `len3` = 10; drop `req[3]` when `value` = 4 -> `abort` = 1 with `done_id` = 3, no `done`; the next grant goes to the lowest pending requester at or above index 0 (`ptr` = 0).
- **Reset mid-count:** `reset` low at `value` = 7 -> after that edge `grant` = 0, `value` = 0, `busy` = 0, no pulse. With `reset` back high and `req` = 0010 still held, `grant` = 0010 one edge later.
- **Length change during grant:** change `len0` from 3 to 9 while `value` = 1 -> counting stops at 3; `done` fires at the original time.
